// File: rtl/t16_pkg.sv
// Shared definitions for the tiny16 execute controller: opcodes, ALU op codes,
// flag bit positions, branch conditions and the controller state encoding.
package t16_pkg;

  localparam logic [3:0] OPC_ADD   = 4'h0;
  localparam logic [3:0] OPC_SUB   = 4'h1;
  localparam logic [3:0] OPC_AND   = 4'h2;
  localparam logic [3:0] OPC_OR    = 4'h3;
  localparam logic [3:0] OPC_SHIFT = 4'h4;
  localparam logic [3:0] OPC_LDUI  = 4'h5;
  localparam logic [3:0] OPC_LDLI  = 4'h6;
  localparam logic [3:0] OPC_CMP   = 4'h7;
  localparam logic [3:0] OPC_BCC   = 4'h8;

  localparam logic [2:0] ALU_ADD   = 3'd0;
  localparam logic [2:0] ALU_SUB   = 3'd1;
  localparam logic [2:0] ALU_AND   = 3'd2;
  localparam logic [2:0] ALU_OR    = 3'd3;
  localparam logic [2:0] ALU_SHIFT = 3'd4;
  localparam logic [2:0] ALU_LDUI  = 3'd5;

  // Flags are packed {z,c,n,v}
  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 0;

  localparam logic [2:0] COND_ALWAYS = 3'd0;
  localparam logic [2:0] COND_Z      = 3'd1;
  localparam logic [2:0] COND_NZ     = 3'd2;
  localparam logic [2:0] COND_C      = 3'd3;
  localparam logic [2:0] COND_NC     = 3'd4;
  localparam logic [2:0] COND_N      = 3'd5;
  localparam logic [2:0] COND_NN     = 3'd6;
  localparam logic [2:0] COND_V      = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } state_t;

  function automatic logic cond_met(input logic [2:0] cond, input logic [3:0] f);
    logic hit;
    hit = 1'b0;
    case (cond)
      COND_ALWAYS: hit = 1'b1;
      COND_Z:      hit = f[FLAG_Z];
      COND_NZ:     hit = ~f[FLAG_Z];
      COND_C:      hit = f[FLAG_C];
      COND_NC:     hit = ~f[FLAG_C];
      COND_N:      hit = f[FLAG_N];
      COND_NN:     hit = ~f[FLAG_N];
      COND_V:      hit = f[FLAG_V];
      default:     hit = 1'b0;
    endcase
    return hit;
  endfunction

  function automatic logic writes_rd(input logic [3:0] opc);
    return opc <= OPC_LDLI;
  endfunction

  function automatic logic updates_flags(input logic [3:0] opc);
    return opc <= OPC_CMP;
  endfunction

endpackage

// File: rtl/t16_regfile.sv
// 8x16 register file: two operand read ports, one debug read port and one
// synchronous write port. r0 always reads zero and ignores writes.
module t16_regfile
  import t16_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_we,
  input  logic [2:0]  i_waddr,
  input  logic [15:0] i_wdata,
  input  logic [2:0]  i_raddr1,
  input  logic [2:0]  i_raddr2,
  input  logic [2:0]  i_dbg_addr,
  output logic [15:0] o_rdata1,
  output logic [15:0] o_rdata2,
  output logic [15:0] o_dbg_data
);

  logic [15:0] r_mem [8];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) r_mem[i] <= '0;
    end else if (i_we && (i_waddr != 3'd0)) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Reads are combinational, so a same-cycle write is seen only after the edge
  assign o_rdata1   = (i_raddr1   == 3'd0) ? 16'h0000 : r_mem[i_raddr1];
  assign o_rdata2   = (i_raddr2   == 3'd0) ? 16'h0000 : r_mem[i_raddr2];
  assign o_dbg_data = (i_dbg_addr == 3'd0) ? 16'h0000 : r_mem[i_dbg_addr];

endmodule

// File: rtl/t16_exec.sv
// tiny16 execute controller: accepts one instruction per four cycles, drives an
// external ALU, captures its result and flags, and writes back or branches.
module t16_exec
  import t16_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [15:0] instr,
  output logic [2:0]  alu_op,
  output logic [15:0] alu_in1,
  output logic [15:0] alu_in2,
  input  logic [15:0] alu_out,
  input  logic [3:0]  alu_flags,
  output logic        done,
  output logic        illegal,
  output logic        br_taken,
  output logic [7:0]  br_offset,
  output logic [3:0]  flags,
  input  logic [2:0]  dbg_addr,
  output logic [15:0] dbg_data
);

  state_t      r_state;
  logic [15:0] r_instr;
  logic [2:0]  r_alu_op;
  logic [15:0] r_alu_in1;
  logic [15:0] r_alu_in2;
  logic [15:0] r_result;
  logic [3:0]  r_alu_flags;
  logic [3:0]  r_flags;
  logic        r_done;
  logic        r_illegal;
  logic        r_br_taken;
  logic [7:0]  r_br_offset;

  logic [3:0]  w_opc;
  logic [2:0]  w_rd;
  logic [7:0]  w_imm;
  logic [15:0] w_rdata1;
  logic [15:0] w_rdata2;
  logic        w_we;

  assign w_opc = r_instr[15:12];
  assign w_rd  = r_instr[11:9];
  assign w_imm = r_instr[7:0];
  assign w_we  = (r_state == ST_WB) && writes_rd(w_opc);

  t16_regfile u_regfile (
    .clk        (clk),
    .rst        (rst),
    .i_we       (w_we),
    .i_waddr    (w_rd),
    .i_wdata    (r_result),
    .i_raddr1   (r_instr[8:6]),
    .i_raddr2   (r_instr[5:3]),
    .i_dbg_addr (dbg_addr),
    .o_rdata1   (w_rdata1),
    .o_rdata2   (w_rdata2),
    .o_dbg_data (dbg_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_instr     <= '0;
      r_alu_op    <= '0;
      r_alu_in1   <= '0;
      r_alu_in2   <= '0;
      r_result    <= '0;
      r_alu_flags <= '0;
      r_flags     <= '0;
      r_done      <= 1'b0;
      r_illegal   <= 1'b0;
      r_br_taken  <= 1'b0;
      r_br_offset <= '0;
    end else begin
      r_done     <= 1'b0;
      r_illegal  <= 1'b0;
      r_br_taken <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (instr_valid) begin
            r_instr <= instr;
            r_state <= ST_READ;
          end
        end
        ST_READ: begin
          // Branches and illegal opcodes leave the ALU port untouched
          case (w_opc)
            OPC_ADD, OPC_SUB, OPC_AND, OPC_OR, OPC_SHIFT: begin
              r_alu_op  <= w_opc[2:0];
              r_alu_in1 <= w_rdata1;
              r_alu_in2 <= w_rdata2;
            end
            OPC_LDUI: begin
              r_alu_op  <= ALU_LDUI;
              r_alu_in1 <= '0;
              r_alu_in2 <= {8'h00, w_imm};
            end
            OPC_LDLI: begin
              r_alu_op  <= ALU_OR;
              r_alu_in1 <= '0;
              r_alu_in2 <= {8'h00, w_imm};
            end
            OPC_CMP: begin
              r_alu_op  <= ALU_SUB;
              r_alu_in1 <= w_rdata1;
              r_alu_in2 <= w_rdata2;
            end
            default: ;
          endcase
          r_state <= ST_EXEC;
        end
        ST_EXEC: begin
          // The ALU latched its flags at the mid-cycle negedge; both are stable here
          r_result    <= alu_out;
          r_alu_flags <= alu_flags;
          r_state     <= ST_WB;
        end
        ST_WB: begin
          r_done <= 1'b1;
          if (updates_flags(w_opc)) r_flags <= r_alu_flags;
          if (w_opc == OPC_BCC) begin
            r_br_offset <= w_imm;
            r_br_taken  <= cond_met(w_rd, r_flags);
          end
          if (w_opc > OPC_BCC) r_illegal <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign instr_ready = (r_state == ST_IDLE);
  assign alu_op      = r_alu_op;
  assign alu_in1     = r_alu_in1;
  assign alu_in2     = r_alu_in2;
  assign done        = r_done;
  assign illegal     = r_illegal;
  assign br_taken    = r_br_taken;
  assign br_offset   = r_br_offset;
  assign flags       = r_flags;

endmodule
